// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM with Moore datapath controls, an ALU decoder and a retired-instruction counter.
// Define MIPS_MC_BNE_EN to add bne support (BNEEX state); otherwise opcode 000101 is illegal.
module mips_mc_controller #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                pcen,
  output logic                irwrite,
  output logic                memwrite,
  output logic                regwrite,
  output logic                iord,
  output logic                alusrca,
  output logic                memtoreg,
  output logic                regdst,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [2:0]          alucontrol,
  output logic                illegal,
  output logic [RETIRE_W-1:0] instret
);
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  state_t     state;
  logic       pcwrite, branch, branchn;
  logic [1:0] aluop;

  // Terminal states retire the instruction as they hand back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYP:      state <= RTYPEEX;
            OP_BEQ:       state <= BEQEX;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JEX;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:       state <= BNEEX;
`endif
            default:      state <= FETCH;
          endcase
        end
        MEMADR:  state <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   state <= MEMWB;
        RTYPEEX: state <= RTYPEWB;
        ADDIEX:  state <= ADDIWB;
        MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX, BNEEX: begin
          state   <= FETCH;
          instret <= instret + RETIRE_W'(1);
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchn  = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;
    case (state)
      FETCH:   begin irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:  illegal = 1'b0;
`endif
          default: illegal = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
      MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
      RTYPEWB: begin regdst = 1'b1; regwrite = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
      ADDIWB:  regwrite = 1'b1;
      JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
`ifdef MIPS_MC_BNE_EN
      BNEEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branchn = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign pcen = pcwrite | (branch & zero) | (branchn & ~zero);

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
    endcase
  end
endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: directed and random instructions against a per-phase table model.
// A narrow instret (4 bits) lets the random run cover counter wrap.
module tb_mips_mc_controller;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   op, funct;
  logic         zero;
  logic         pcen, irwrite, memwrite, regwrite, iord, alusrca, memtoreg, regdst;
  logic [1:0]   alusrcb, pcsrc;
  logic [2:0]   alucontrol;
  logic         illegal;
  logic [W-1:0] instret;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] cnt_model = '0;

  mips_mc_controller #(.RETIRE_W(W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .alusrca(alusrca), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010,
                         BNE = 6'b000101;

`ifdef MIPS_MC_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return (o == LW || o == SW || o == RT || o == BEQ || o == ADDI || o == JMP ||
            (o == BNE && BNE_ON));
  endfunction

  // Cycles from FETCH back to FETCH.
  function automatic int latency(input logic [5:0] o);
    if (!is_legal(o)) return 2;
    if (o == LW) return 5;
    if (o == SW || o == RT || o == ADDI) return 4;
    return 3;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [3:0] exp_state(input logic [5:0] o, input int ph);
    if (ph < 2) return 4'(ph);
    case (o)
      LW:      return (ph == 2) ? 4'd2 : (ph == 3) ? 4'd3 : 4'd4;
      SW:      return (ph == 2) ? 4'd2 : 4'd5;
      RT:      return (ph == 2) ? 4'd6 : 4'd7;
      BEQ:     return 4'd8;
      ADDI:    return (ph == 2) ? 4'd9 : 4'd10;
      JMP:     return 4'd11;
      default: return 4'd12;
    endcase
  endfunction

  // {pcen,irwrite,memwrite,regwrite,iord,alusrca,memtoreg,regdst,alusrcb,pcsrc,alucontrol,illegal}
  function automatic logic [15:0] exp_ctrl(input logic [5:0] o, input logic [5:0] f,
                                           input logic z, input int ph);
    logic pe = 0, irw = 0, mw = 0, rw = 0, io = 0, sa = 0, m2r = 0, rd = 0, ill = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] alu = 3'b010;
    if (ph == 0) begin pe = 1; irw = 1; sb = 2'b01; end
    else if (ph == 1) begin sb = 2'b11; ill = !is_legal(o); end
    else begin
      case (o)
        LW, SW: begin
          if (ph == 2) begin sa = 1; sb = 2'b10; end
          else if (ph == 3) begin io = 1; mw = (o == SW); end
          else begin m2r = 1; rw = 1; end
        end
        RT:   if (ph == 2) begin sa = 1; alu = funct_alu(f); end else begin rd = 1; rw = 1; end
        BEQ:  begin sa = 1; alu = 3'b110; ps = 2'b01; pe = z; end
        ADDI: if (ph == 2) begin sa = 1; sb = 2'b10; end else rw = 1;
        JMP:  begin ps = 2'b10; pe = 1; end
        default: begin sa = 1; alu = 3'b110; ps = 2'b01; pe = ~z; end
      endcase
    end
    return {pe, irw, mw, rw, io, sa, m2r, rd, sb, ps, alu, ill};
  endfunction

  function automatic logic [15:0] obs_ctrl();
    return {pcen, irwrite, memwrite, regwrite, iord, alusrca, memtoreg, regdst,
            alusrcb, pcsrc, alucontrol, illegal};
  endfunction

  // Entered mid-cycle with the FSM in FETCH; leaves mid-cycle back in FETCH.
  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
    #1;
    for (int ph = 0; ph < latency(o); ph++) begin
      chk($sformatf("%s op=%b ph%0d ctrl", tag, o, ph), 32'(obs_ctrl()), 32'(exp_ctrl(o, f, z, ph)));
      chk($sformatf("%s op=%b ph%0d state", tag, o, ph), 32'(dut.state), 32'(exp_state(o, ph)));
      @(posedge clk); #1;
    end
    chk($sformatf("%s op=%b end state", tag, o), 32'(dut.state), 32'd0);
    if (is_legal(o)) cnt_model = cnt_model + 1'b1;
    chk($sformatf("%s op=%b instret", tag, o), 32'(instret), 32'(cnt_model));
  endtask

  logic [5:0] op_pool [8];
  logic [5:0] fn_pool [6];

  initial begin
    op_pool = '{LW, SW, RT, BEQ, ADDI, JMP, BNE, 6'b111111};
    fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    reset = 1'b1; op = RT; funct = 6'b100000; zero = 1'b0;
    #3;
    chk("reset ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(RT, 6'b100000, 1'b0, 0)));
    chk("reset state", 32'(dut.state), 32'd0);
    chk("reset instret", 32'(instret), 32'd0);
    @(posedge clk); #1;
    chk("reset held state", 32'(dut.state), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_instr("lw", LW, 6'b000000, 1'b0);
    run_instr("beq_taken", BEQ, 6'b000000, 1'b1);
    run_instr("beq_nottaken", BEQ, 6'b000000, 1'b0);
    run_instr("rtype_slt", RT, 6'b101010, 1'b0);
    run_instr("illegal", 6'b111111, 6'b000000, 1'b0);
    run_instr("bne", BNE, 6'b000000, 1'b0);
    run_instr("sw", SW, 6'b000000, 1'b1);
    run_instr("j", JMP, 6'b000000, 1'b0);
    run_instr("addi", ADDI, 6'b000000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [5:0] o, f;
      o = op_pool[$urandom_range(0, 7)];
      if (o == 6'b111111) o = 6'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)];
      run_instr("rand", o, f, 1'($urandom));
    end

    // Reset in the middle of a load, while parked in MEMRD.
    op = LW; funct = 6'b000000; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midop pre state", 32'(dut.state), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("midop reset state", 32'(dut.state), 32'd0);
    chk("midop reset instret", 32'(instret), 32'd0);
    chk("midop reset ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(LW, 6'b000000, 1'b0, 0)));
    @(negedge clk);
    reset = 1'b0;
    cnt_model = '0;
    run_instr("post_reset", LW, 6'b000000, 1'b0);
    run_instr("post_reset", RT, 6'b100010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
